// File: rtl/display_scan_controller.sv
// Scans NUM_DIGITS common-anode seven-segment digits through one shared 5-bit decoder,
// swapping new data in only at frame boundaries, with dead time and leading-zero blanking.
module display_scan_controller #(
  parameter int NUM_DIGITS = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 2,
  parameter logic [4:0] BLANK_CODE = 5'd31,
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    lz_en,
  input  logic                    upd_valid,
  input  logic [NUM_DIGITS*5-1:0] upd_data,
  output logic                    upd_ready,
  output logic [4:0]              code_out,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    frame_tick
);

  localparam int CNT_MAX = (REFRESH_DIV > DEAD_CYCLES)
                         ? ((REFRESH_DIV > 2) ? REFRESH_DIV : 2)
                         : ((DEAD_CYCLES > 2) ? DEAD_CYCLES : 2);
  localparam int CNT_W = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST    = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {S_OFF, S_ON, S_DEAD} state_t;

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             pending_reg, pending_next;
  logic [4:0]       display_reg [NUM_DIGITS];
  logic [4:0]       shadow_reg  [NUM_DIGITS];

  logic                  accept;
  logic                  swap;
  logic                  boundary;
  logic [IDX_W-1:0]      idx_inc;
  logic [NUM_DIGITS-1:0] blank_mask;
  logic                  zero_run;

  assign idx_inc = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    boundary   = 1'b0;
    if (!en) begin
      state_next = S_OFF;
      idx_next   = '0;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        S_OFF: begin
          state_next = S_ON;
          idx_next   = '0;
          cnt_next   = '0;
          boundary   = 1'b1;
        end
        S_ON: begin
          if (cnt_reg == REFRESH_LAST) begin
            cnt_next = '0;
            if (DEAD_CYCLES > 0) begin
              state_next = S_DEAD;
            end else begin
              idx_next = idx_inc;
              boundary = (idx_reg == IDX_LAST);
            end
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        S_DEAD: begin
          if (cnt_reg == DEAD_LAST) begin
            cnt_next   = '0;
            state_next = S_ON;
            idx_next   = idx_inc;
            boundary   = (idx_reg == IDX_LAST);
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        default: begin
          state_next = S_OFF;
          idx_next   = '0;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Swap lands on the edge entering a frame, so a frame is never half old, half new.
  assign accept = upd_valid && !pending_reg;
  assign swap   = pending_reg && (boundary || (state_reg == S_OFF));

  always_comb begin
    pending_next = pending_reg;
    if (swap) begin
      pending_next = 1'b0;
    end else if (accept) begin
      pending_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_OFF;
      idx_reg     <= '0;
      cnt_reg     <= '0;
      pending_reg <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        display_reg[i] <= BLANK_CODE;
        shadow_reg[i]  <= BLANK_CODE;
      end
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      cnt_reg     <= cnt_next;
      pending_reg <= pending_next;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (swap) begin
          display_reg[i] <= shadow_reg[i];
        end
        if (accept) begin
          shadow_reg[i] <= upd_data[5*i +: 5];
        end
      end
    end
  end

  // A digit is blankable when it and every digit above it hold code 0; digit 0 never is.
  always_comb begin
    zero_run   = 1'b1;
    blank_mask = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run      = zero_run && (display_reg[i] == 5'd0);
      blank_mask[i] = zero_run && (i != 0);
    end
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_anode
    assign an[gi] = !((state_reg == S_ON) && (idx_reg == IDX_W'(gi)));
  end

  always_comb begin
    code_out = BLANK_CODE;
    if (state_reg == S_ON) begin
      code_out = (lz_en && blank_mask[idx_reg]) ? BLANK_CODE : display_reg[idx_reg];
    end
  end

  assign upd_ready  = !pending_reg;
  assign digit_idx  = idx_reg;
  assign frame_tick = (state_reg == S_ON) && (idx_reg == '0) && (cnt_reg == '0);

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller: two instances (dead time 1 and 0) checked every cycle
// against a frame-position model, plus directed scenarios with hand-computed expectations.
module tb_display_scan_controller;

  localparam int N = 4;
  localparam int R = 4;

  logic        clk = 1'b0;
  logic        reset, en, lz_en, upd_valid;
  logic [19:0] upd_data;

  logic       ready_a, tick_a, ready_b, tick_b;
  logic [4:0] code_a, code_b;
  logic [3:0] an_a, an_b;
  logic [1:0] idx_a, idx_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  display_scan_controller #(.NUM_DIGITS(4), .REFRESH_DIV(4), .DEAD_CYCLES(1), .BLANK_CODE(5'd31)) dut_a (
    .clk(clk), .reset(reset), .en(en), .lz_en(lz_en), .upd_valid(upd_valid), .upd_data(upd_data),
    .upd_ready(ready_a), .code_out(code_a), .an(an_a), .digit_idx(idx_a), .frame_tick(tick_a));

  display_scan_controller #(.NUM_DIGITS(4), .REFRESH_DIV(4), .DEAD_CYCLES(0), .BLANK_CODE(5'd31)) dut_b (
    .clk(clk), .reset(reset), .en(en), .lz_en(lz_en), .upd_valid(upd_valid), .upd_data(upd_data),
    .upd_ready(ready_b), .code_out(code_b), .an(an_b), .digit_idx(idx_b), .frame_tick(tick_b));

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: each instance is described by "cycles since enable" and the data buffers.
  int          dead_c [2] = '{1, 0};
  string       pfx    [2] = '{"a.", "b."};
  logic        m_on   [2];
  int          m_t    [2];
  logic        m_pend [2];
  logic [4:0]  m_disp [2][N];
  logic [4:0]  m_shad [2][N];
  bit          mvalid = 1'b0;
  int          frame_len, nt;
  logic        acc, swp, bnd;

  always @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (reset) begin
        m_on[c] = 1'b0;
        m_t[c] = 0;
        m_pend[c] = 1'b0;
        for (int d = 0; d < N; d++) begin
          m_disp[c][d] = 5'd31;
          m_shad[c][d] = 5'd31;
        end
      end else begin
        frame_len = N * (R + dead_c[c]);
        acc = upd_valid && !m_pend[c];
        nt = (en && m_on[c]) ? m_t[c] + 1 : 0;
        bnd = en && (nt % frame_len == 0);
        swp = m_pend[c] && (bnd || !m_on[c]);
        for (int d = 0; d < N; d++) begin
          if (swp) m_disp[c][d] = m_shad[c][d];
          if (acc) m_shad[c][d] = upd_data[5*d +: 5];
        end
        m_pend[c] = swp ? 1'b0 : (acc ? 1'b1 : m_pend[c]);
        m_on[c] = en;
        m_t[c] = nt;
      end
    end
    if (reset) mvalid = 1'b1;
  end

  function automatic logic [4:0] eff(input int c, input int s);
    bit allz = 1'b1;
    for (int j = s; j < N; j++) if (m_disp[c][j] != 5'd0) allz = 1'b0;
    if (lz_en && s > 0 && allz) return 5'd31;
    return m_disp[c][s];
  endfunction

  logic [3:0] e_an;
  logic [4:0] e_code;
  logic [3:0] one4 = 4'b0001;
  int         e_idx, e_tick, e_pos, e_len;

  always @(negedge clk) begin
    if (mvalid) begin
      for (int c = 0; c < 2; c++) begin
        e_an = 4'hF; e_code = 5'd31; e_idx = 0; e_tick = 0;
        if (m_on[c]) begin
          e_len  = R + dead_c[c];
          e_pos  = m_t[c] % (N * e_len);
          e_idx  = e_pos / e_len;
          e_tick = (e_pos == 0) ? 1 : 0;
          if (e_pos % e_len < R) begin
            e_an   = ~(one4 << e_idx);
            e_code = eff(c, e_idx);
          end
        end
        chk({pfx[c], "an"},    (c == 0) ? an_a : an_b, e_an);
        chk({pfx[c], "code"},  (c == 0) ? code_a : code_b, e_code);
        chk({pfx[c], "idx"},   (c == 0) ? idx_a : idx_b, e_idx);
        chk({pfx[c], "tick"},  (c == 0) ? tick_a : tick_b, e_tick);
        chk({pfx[c], "ready"}, (c == 0) ? ready_a : ready_b, m_pend[c] ? 0 : 1);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(input string tag);
    int n = 0;
    do begin step(1); n++; end while (!tick_a && n < 60);
    chk({tag, ".tick_seen"}, tick_a, 1);
  endtask

  task automatic wait_lit(input int d);
    int n = 0;
    logic [3:0] pat;
    pat = ~(4'b0001 << d);
    while (!(idx_a == 2'(d) && an_a == pat) && n < 60) begin step(1); n++; end
    chk("wait_lit", an_a, pat);
  endtask

  task automatic offer(input logic [19:0] data);
    int n = 0;
    while (!ready_a && n < 60) begin step(1); n++; end
    chk("offer.ready", ready_a, 1);
    upd_data = data;
    upd_valid = 1'b1;
    step(1);
    upd_valid = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic [4:0] e0, e1, e2, e3);
    logic [4:0] e [4];
    e = '{e0, e1, e2, e3};
    wait_tick(tag);
    chk({tag, ".ready"}, ready_a, 1);
    for (int d = 0; d < 4; d++) begin
      chk({tag, ".code"}, code_a, e[d]);
      chk({tag, ".idx"}, idx_a, d);
      if (d < 3) step(5);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".an"}, an_a, 4'hF);
    chk({tag, ".code"}, code_a, 31);
    chk({tag, ".idx"}, idx_a, 0);
    chk({tag, ".tick"}, tick_a, 0);
    chk({tag, ".ready"}, ready_a, 1);
  endtask

  logic [3:0] seq1 [20] = '{4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD, 4'hD, 4'hF,
                            4'hB, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7, 4'h7, 4'hF};

  initial begin
    int n, gaps;
    reset = 1'b1; en = 1'b0; lz_en = 1'b0; upd_valid = 1'b0; upd_data = '0;
    step(2);
    check_reset_outputs("reset");
    reset = 1'b0;
    step(1);

    // Plain scan, no data: literal anode sequence and 20-cycle frame.
    en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step(1);
      chk("s1.an", an_a, seq1[k]);
      chk("s1.code", code_a, 31);
      chk("s1.tick", tick_a, (k == 0) ? 1 : 0);
    end
    step(1);
    chk("s1.tick20", tick_a, 1);

    // Update offered while digit 2 is lit.
    wait_lit(2);
    upd_data = {5'd1, 5'd2, 5'd3, 5'd4};
    upd_valid = 1'b1;
    step(1);
    upd_valid = 1'b0;
    chk("s2.ready_drop", ready_a, 0);
    check_frame("s2", 5'd4, 5'd3, 5'd2, 5'd1);

    // Leading-zero blanking.
    lz_en = 1'b1;
    offer({5'd0, 5'd0, 5'd7, 5'd0});
    check_frame("s3a", 5'd0, 5'd7, 5'd31, 5'd31);
    lz_en = 1'b0;
    check_frame("s3b", 5'd0, 5'd7, 5'd0, 5'd0);
    lz_en = 1'b1;
    offer(20'd0);
    check_frame("s3c", 5'd0, 5'd31, 5'd31, 5'd31);
    lz_en = 1'b0;

    // Drop enable mid-slot, then restart with a full slot.
    wait_lit(2);
    step(1);
    en = 1'b0;
    step(1);
    chk("s4.an_off", an_a, 4'hF);
    chk("s4.idx_off", idx_a, 0);
    step(2);
    en = 1'b1;
    step(1);
    chk("s4.tick", tick_a, 1);
    chk("s4.an0", an_a, 4'hE);
    step(3);
    chk("s4.an3", an_a, 4'hE);
    step(1);
    chk("s4.dead", an_a, 4'hF);

    // Update while disabled swaps immediately.
    en = 1'b0;
    step(2);
    offer({5'd9, 5'd9, 5'd9, 5'd9});
    chk("s5.ready_c1", ready_a, 0);
    step(1);
    chk("s5.ready_c2", ready_a, 1);
    en = 1'b1;
    step(1);
    chk("s5.tick", tick_a, 1);
    chk("s5.code", code_a, 9);
    check_frame("s5", 5'd9, 5'd9, 5'd9, 5'd9);

    // Reset during dead time discards pending data.
    wait_tick("s6");
    offer({5'd5, 5'd5, 5'd5, 5'd5});
    n = 0;
    while (an_a != 4'hF && n < 20) begin step(1); n++; end
    chk("s6.in_dead", an_a, 4'hF);
    chk("s6.pending", ready_a, 0);
    reset = 1'b1;
    step(1);
    check_reset_outputs("s6.reset");
    reset = 1'b0;
    check_frame("s6", 5'd31, 5'd31, 5'd31, 5'd31);

    // Frame periods: 20 with dead time, 16 without and no dark gaps.
    n = 0;
    while (!tick_b && n < 40) begin step(1); n++; end
    n = 0; gaps = 0;
    do begin step(1); n++; if (an_b == 4'hF) gaps++; end while (!tick_b && n < 40);
    chk("s7.period_b", n, 16);
    chk("s7.gaps_b", gaps, 0);
    n = 0;
    while (!tick_a && n < 40) begin step(1); n++; end
    n = 0;
    do begin step(1); n++; end while (!tick_a && n < 40);
    chk("s7.period_a", n, 20);

    // Randomized traffic, checked by the per-cycle model.
    for (int k = 0; k < 2500; k++) begin
      if ($urandom_range(0, 99) < 2) en = !en;
      if ($urandom_range(0, 49) == 0) lz_en = !lz_en;
      reset = ($urandom_range(0, 399) == 0);
      upd_valid = ($urandom_range(0, 3) == 0);
      for (int d = 0; d < N; d++)
        upd_data[5*d +: 5] = $urandom_range(0, 1) ? 5'd0 : 5'($urandom_range(0, 31));
      step(1);
    end
    reset = 1'b0;
    upd_valid = 1'b0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

endmodule
